// File: rtl/parity_pkg.sv
// Shared state and parity-mode encodings for the sequential parity generator/checker.
package parity_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CALC = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

   typedef enum logic [1:0] {
      IDLE = ST_IDLE,
      CALC = ST_CALC,
      DONE = ST_DONE
   } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] cnt
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/parity_gen_chk_seq.sv
// Sequential parity generator/checker: folds CHUNK bits per cycle, appends parity, flags mismatches.
module parity_gen_chk_seq
   import parity_pkg::*;
#(
   parameter int WIDTH = 9,
   parameter int CHUNK = 3,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_par,
   input  logic             odd_sel,
   input  logic             chk_en,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH:0]   out_data,
   output logic             out_err,
   output logic [CNT_W-1:0] err_cnt,
   input  logic             cnt_clr
);

   localparam int N      = WIDTH / CHUNK;
   localparam int BEAT_W = (N > 1) ? $clog2(N) : 1;

   if ((WIDTH < 1) || (CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_bad_params
      $error("parity_gen_chk_seq: WIDTH must be >= 1 and an exact multiple of CHUNK");
   end

   state_t              state_q, state_d;
   logic [WIDTH-1:0]    shift_q, shift_d;
   logic [WIDTH-1:0]    data_q, data_d;
   logic                acc_q, acc_d;
   logic [BEAT_W-1:0]   beat_q, beat_d;
   logic                odd_q, odd_d;
   logic                chk_q, chk_d;
   logic                par_q, par_d;
   logic [WIDTH:0]      out_data_q, out_data_d;
   logic                out_err_q, out_err_d;
   logic                fold;
   logic                parity;

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign out_data  = out_data_q;
   assign out_err   = out_err_q;

   // fold/parity already include the current beat so the last CALC cycle can register the result directly
   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      data_d     = data_q;
      acc_d      = acc_q;
      beat_d     = beat_q;
      odd_d      = odd_q;
      chk_d      = chk_q;
      par_d      = par_q;
      out_data_d = out_data_q;
      out_err_d  = out_err_q;
      fold       = acc_q ^ (^shift_q[CHUNK-1:0]);
      parity     = fold ^ (odd_q == PAR_ODD);

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               shift_d = in_data;
               data_d  = in_data;
               odd_d   = odd_sel;
               chk_d   = chk_en;
               par_d   = in_par;
               acc_d   = 1'b0;
               beat_d  = '0;
               state_d = CALC;
            end
         end
         CALC: begin
            acc_d   = fold;
            shift_d = shift_q >> CHUNK;
            beat_d  = beat_q + BEAT_W'(1);
            if (beat_q == BEAT_W'(N - 1)) begin
               out_data_d = {parity, data_q};
               out_err_d  = chk_q & (parity != par_q);
               state_d    = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         shift_q    <= '0;
         data_q     <= '0;
         acc_q      <= 1'b0;
         beat_q     <= '0;
         odd_q      <= PAR_EVEN;
         chk_q      <= 1'b0;
         par_q      <= 1'b0;
         out_data_q <= '0;
         out_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         data_q     <= data_d;
         acc_q      <= acc_d;
         beat_q     <= beat_d;
         odd_q      <= odd_d;
         chk_q      <= chk_d;
         par_q      <= par_d;
         out_data_q <= out_data_d;
         out_err_q  <= out_err_d;
      end
   end

   sat_counter #(
      .CNT_W(CNT_W)
   ) u_err_cnt (
      .clk  (clk),
      .rst_n(rst_n),
      .clr  (cnt_clr),
      .inc  (out_valid && out_ready && out_err_q),
      .cnt  (err_cnt)
   );

endmodule
